uart_rx_byte: RTL

- Asynchronous serial receiver, 8N1, LSB first.
- Sits directly upstream of the digital-clock control block and drives its rx_data / rx_data_rdy inputs.
- Converts the raw rxd pin into validated bytes, one per frame, each marked by a single-cycle ready strobe.
- Reports framing errors and line activity.

---
 rtl/uart_rx_byte.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
`timescale 1ns / 1ps
// 8N1 asynchronous serial receiver, LSB first, oversampled from a divided tick.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx_byte #(
   parameter int CLK_HZ     = 12000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DIV        = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_data_rdy,
   output logic       rx_frame_err,
   output logic       rx_busy,
   output logic       rx_parity_err,
   output logic [2:0] dbgState
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BRK    = 3'd5
   } rxStateT;

   rxStateT        state;
   logic [1:0]     rxSync;
   logic           rxs;
   logic [DW-1:0]  divCnt;
   logic           tick;
   logic [SW-1:0]  sCnt;
   logic [2:0]     bCnt;
   logic [7:0]     shReg;
   logic           lastSample;
`ifdef UART_RX_PARITY_EN
   logic           parBit;
`endif

   // Two-flop synchronizer; resets to the idle (mark) level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rxSync <= 2'b11;
      else     rxSync <= {rxSync[0], rxd};
   end

   assign rxs        = rxSync[1];
   assign tick       = (divCnt == DW'(DIV - 1));
   assign lastSample = (sCnt == SW'(OVERSAMPLE - 1));
   assign rx_busy    = (state != IDLE);
   assign dbgState   = state;

`ifndef UART_RX_PARITY_EN
   assign rx_parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         divCnt       <= '0;
         sCnt         <= '0;
         bCnt         <= '0;
         shReg        <= '0;
         rx_data      <= '0;
         rx_data_rdy  <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parBit        <= 1'b0;
         rx_parity_err <= 1'b0;
`endif
      end else begin
         rx_data_rdy  <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
         // Tick phase restarts from each start edge so samples land mid-bit.
         if (state == IDLE || tick) divCnt <= '0;
         else                       divCnt <= divCnt + 1'b1;

         case (state)
            IDLE: begin
               if (!rxs) begin
                  sCnt  <= '0;
                  state <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (sCnt == SW'(OVERSAMPLE / 2 - 1)) begin
                     if (rxs) begin
                        state <= IDLE;
                     end else begin
                        sCnt  <= '0;
                        bCnt  <= '0;
                        state <= DATA;
                     end
                  end else begin
                     sCnt <= sCnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (lastSample) begin
                     sCnt  <= '0;
                     shReg <= {rxs, shReg[7:1]};
                     bCnt  <= bCnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                     if (bCnt == 3'd7) state <= PARITY;
`else
                     if (bCnt == 3'd7) state <= STOP;
`endif
                  end else begin
                     sCnt <= sCnt + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (lastSample) begin
                     sCnt   <= '0;
                     parBit <= rxs;
                     state  <= STOP;
                  end else begin
                     sCnt <= sCnt + 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (lastSample) begin
                     sCnt <= '0;
                     // A low stop bit outranks any parity result.
                     if (!rxs) begin
                        rx_frame_err <= 1'b1;
                        state        <= BRK;
`ifdef UART_RX_PARITY_EN
                     end else if ((^shReg) != parBit) begin
                        rx_parity_err <= 1'b1;
                        state         <= IDLE;
`endif
                     end else begin
                        rx_data     <= shReg;
                        rx_data_rdy <= 1'b1;
                        state       <= IDLE;
                     end
                  end else begin
                     sCnt <= sCnt + 1'b1;
                  end
               end
            end
            BRK: begin
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
